// File: rtl/replay_pkg.sv
// Shared types and helpers for the replay transmit controller.
// Sequence distance is computed modulo 2^w so callers can use any SEQ_W up to 32.
package replay_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SEND,
    S_REPLAY
  } state_e;

  localparam int unsigned DEF_SEQ_W = 8;
  localparam int unsigned DEF_DEPTH = 8;

  // Number of entries an ACK for seq 'ack' retires when 'oldest' is the oldest unacked seq.
  function automatic logic [31:0] seq_dist(input logic [31:0] ack, input logic [31:0] oldest,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (32'd1 << w) - 32'd1;
    return (ack - oldest + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/replay_ram.sv
// Replay store: one synchronous write port and one asynchronous read port.
module replay_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/replay_tx_ctrl.sv
// Pops fifo words, tags them with a sequence number, keeps a replay copy and
// retires/replays stored copies according to ACK/NAK from the link partner.
module replay_tx_ctrl
  import replay_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SEQ_W      = DEF_SEQ_W,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned REPLAY_MAX = 3,
  localparam int unsigned PTR_W     = $clog2(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              EN,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [SEQ_W-1:0]  tx_seq,
  input  logic              ack_valid,
  input  logic              ack_nak,
  input  logic [SEQ_W-1:0]  ack_seq,
  output logic              REPLAY_FULL,
  output logic [CNT_W-1:0]  replay_count,
  output logic              replay_active,
  output logic              link_retrain
);

  localparam int unsigned RN_W = $clog2(REPLAY_MAX + 1);
  localparam int unsigned ST_W = SEQ_W + DATA_W;

  state_e              r_state;
  logic [CNT_W-1:0]    r_wr_ptr;
  logic [CNT_W-1:0]    r_ack_ptr;
  logic [CNT_W-1:0]    r_tx_ptr;
  logic [SEQ_W-1:0]    r_next_seq;
  logic [SEQ_W-1:0]    r_oldest_seq;
  logic [RN_W-1:0]     r_replay_num;
  logic                r_replay_pending;
  logic                r_tx_valid;
  logic [DATA_W-1:0]   r_tx_data;
  logic [SEQ_W-1:0]    r_tx_seq;
  logic                r_replay_active;
  logic                r_link_retrain;

  logic [CNT_W-1:0]    w_count;
  logic [SEQ_W-1:0]    w_dist;
  logic                w_purge;
  logic [CNT_W-1:0]    w_purge_n;
  logic [CNT_W-1:0]    w_count_post;
  logic                w_nak;
  logic                w_replay_go;
  logic                w_fetch;
  logic [CNT_W-1:0]    w_tx_adv;
  logic [PTR_W-1:0]    w_raddr;
  logic                w_we;
  logic [ST_W-1:0]     w_rdata;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign w_count      = r_wr_ptr - r_ack_ptr;
  assign w_dist       = SEQ_W'(seq_dist(32'(ack_seq), 32'(r_oldest_seq), SEQ_W));
  assign w_purge      = ack_valid && (w_dist != '0) && (32'(w_dist) <= 32'(w_count));
  assign w_purge_n    = w_purge ? w_dist[CNT_W-1:0] : '0;
  assign w_count_post = w_count - w_purge_n;
  assign w_nak        = ack_valid && ack_nak;

  assign w_replay_go  = (r_state == S_IDLE) && r_replay_pending && (w_count != '0);
  assign w_fetch      = !Rst && (r_state == S_IDLE) && !w_replay_go && EN && !fifo_empty &&
                        (32'(w_count) < DEPTH);
  assign w_tx_adv     = r_tx_ptr + CNT_W'(1);

  // In S_IDLE the read port looks at the replay start; in S_REPLAY at the next beat.
  assign w_raddr      = (r_state == S_IDLE) ? r_ack_ptr[PTR_W-1:0] : w_tx_adv[PTR_W-1:0];
  assign w_we         = (r_state == S_WAIT);

  replay_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ST_W)
  ) u_ram (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[PTR_W-1:0]),
    .i_wdata ({r_next_seq, fifo_dout}),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state          <= S_IDLE;
      r_wr_ptr         <= '0;
      r_ack_ptr        <= '0;
      r_tx_ptr         <= '0;
      r_next_seq       <= '0;
      r_oldest_seq     <= '0;
      r_replay_num     <= '0;
      r_replay_pending <= 1'b0;
      r_tx_valid       <= 1'b0;
      r_tx_data        <= '0;
      r_tx_seq         <= '0;
      r_replay_active  <= 1'b0;
      r_link_retrain   <= 1'b0;
    end else begin
      r_link_retrain <= 1'b0;

      if (w_purge) begin
        r_ack_ptr    <= r_ack_ptr + w_purge_n;
        r_oldest_seq <= r_oldest_seq + w_dist;
      end

      if (ack_valid && !ack_nak && w_purge) r_replay_num <= '0;

      if (w_nak) begin
        if (32'(r_replay_num) == REPLAY_MAX) begin
          r_link_retrain <= 1'b1;
          r_replay_num   <= '0;
        end else begin
          r_replay_num <= r_replay_num + RN_W'(1);
        end
      end

      // Later assignments take precedence: a fresh NAK beats the entry clear,
      // and an empty store after purge leaves nothing to replay.
      if (w_replay_go) r_replay_pending <= 1'b0;
      if (w_nak) r_replay_pending <= 1'b1;
      if (w_count_post == '0) r_replay_pending <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_replay_go) begin
            r_tx_ptr        <= r_ack_ptr;
            r_tx_seq        <= w_rdata[ST_W-1:DATA_W];
            r_tx_data       <= w_rdata[DATA_W-1:0];
            r_tx_valid      <= 1'b1;
            r_replay_active <= 1'b1;
            r_state         <= S_REPLAY;
          end else if (w_fetch) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_wr_ptr   <= r_wr_ptr + CNT_W'(1);
          r_next_seq <= r_next_seq + SEQ_W'(1);
          r_tx_data  <= fifo_dout;
          r_tx_seq   <= r_next_seq;
          r_tx_valid <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        S_REPLAY: begin
          if (tx_ready) begin
            // A NAK seen mid-replay restarts from the new ack_ptr via S_IDLE.
            if ((w_tx_adv == r_wr_ptr) || r_replay_pending || w_nak) begin
              r_tx_valid      <= 1'b0;
              r_replay_active <= 1'b0;
              r_state         <= S_IDLE;
            end else begin
              r_tx_ptr  <= w_tx_adv;
              r_tx_seq  <= w_rdata[ST_W-1:DATA_W];
              r_tx_data <= w_rdata[DATA_W-1:0];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd       = w_fetch;
  assign tx_valid      = r_tx_valid;
  assign tx_data       = r_tx_data;
  assign tx_seq        = r_tx_seq;
  assign REPLAY_FULL   = (32'(w_count) == DEPTH);
  assign replay_count  = w_count;
  assign replay_active = r_replay_active;
  assign link_retrain  = r_link_retrain;

endmodule

// File: tb/tb_replay_tx_ctrl.sv
// Directed bench for replay_tx_ctrl with a small fifo model and a beat logger.
module tb_replay_tx_ctrl;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SEQ_W      = 4;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned REPLAY_MAX = 3;
  localparam int unsigned CNT_W      = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              EN;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_empty;
  logic              fifo_rd;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic [SEQ_W-1:0]  tx_seq;
  logic              ack_valid;
  logic              ack_nak;
  logic [SEQ_W-1:0]  ack_seq;
  logic              REPLAY_FULL;
  logic [CNT_W-1:0]  replay_count;
  logic              replay_active;
  logic              link_retrain;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  replay_tx_ctrl #(
    .DATA_W     (DATA_W),
    .SEQ_W      (SEQ_W),
    .DEPTH      (DEPTH),
    .REPLAY_MAX (REPLAY_MAX)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .EN            (EN),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_rd       (fifo_rd),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_seq        (tx_seq),
    .ack_valid     (ack_valid),
    .ack_nak       (ack_nak),
    .ack_seq       (ack_seq),
    .REPLAY_FULL   (REPLAY_FULL),
    .replay_count  (replay_count),
    .replay_active (replay_active),
    .link_retrain  (link_retrain)
  );

  // Fifo model: dout valid the cycle after fifo_rd is sampled.
  logic [DATA_W-1:0] fmem [64];
  int   fhead = 0;
  int   ftail = 0;
  logic pop_pend = 1'b0;
  assign fifo_empty = (fhead == ftail);

  always @(posedge Clk) begin
    if (pop_pend) begin
      fifo_dout <= fmem[fhead % 64];
      fhead     <= fhead + 1;
    end
  end

  // Beat logger and fifo_rd counter, sampled mid-cycle.
  logic [SEQ_W-1:0]  log_seq  [64];
  logic [DATA_W-1:0] log_data [64];
  int nlog   = 0;
  int rd_cnt = 0;

  always @(negedge Clk) begin
    pop_pend = fifo_rd;
    if (fifo_rd) rd_cnt++;
    if (tx_valid && tx_ready && nlog < 64) begin
      log_seq[nlog]  = tx_seq;
      log_data[nlog] = tx_data;
      nlog++;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    fmem[ftail % 64] = w;
    ftail++;
  endtask

  task automatic send_ack(input logic nak, input logic [SEQ_W-1:0] s);
    ack_valid = 1'b1;
    ack_nak   = nak;
    ack_seq   = s;
    tick();
    ack_valid = 1'b0;
    ack_nak   = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int k;
    k = 0;
    while (nlog < target && k < 200) begin
      tick();
      k++;
    end
    check("beat_count", 32'(nlog), 32'(target));
  endtask

  task automatic check_beat(input int idx, input logic [SEQ_W-1:0] s, input logic [DATA_W-1:0] d);
    check("beat_seq", 32'(log_seq[idx]), 32'(s));
    check("beat_data", 32'(log_data[idx]), 32'(d));
  endtask

  initial begin
    int k;
    int base_rd;
    Rst       = 1'b1;
    EN        = 1'b0;
    tx_ready  = 1'b1;
    ack_valid = 1'b0;
    ack_nak   = 1'b0;
    ack_seq   = '0;
    repeat (3) tick();

    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_count", 32'(replay_count), 32'd0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("rst_full", 32'(REPLAY_FULL), 32'd0);
    check("rst_active", 32'(replay_active), 32'd0);
    check("rst_retrain", 32'(link_retrain), 32'd0);
    Rst = 1'b0;
    tick();

    // Five words go out tagged 0..4.
    for (int i = 0; i < 5; i++) push(DATA_W'(i));
    EN = 1'b1;
    wait_beats(5);
    EN = 1'b0;
    tick();
    check("t1_rd_pulses", 32'(rd_cnt), 32'd5);
    check("t1_count", 32'(replay_count), 32'd5);
    for (int i = 0; i < 5; i++) check_beat(i, SEQ_W'(i), DATA_W'(i));

    // ACK seq 2 retires three entries; next word carries seq 5.
    send_ack(1'b0, 4'd2);
    check("t2_count", 32'(replay_count), 32'd2);
    push(16'd5);
    EN = 1'b1;
    wait_beats(6);
    EN = 1'b0;
    tick();
    check_beat(5, 4'd5, 16'd5);
    check("t2_count_after", 32'(replay_count), 32'd3);

    // NAK seq 3 retires seq 3 and replays seq 4 and 5.
    send_ack(1'b1, 4'd3);
    check("t3_count", 32'(replay_count), 32'd2);
    k = 0;
    while (!replay_active && k < 20) begin
      tick();
      k++;
    end
    check("t3_active", 32'(replay_active), 32'd1);
    wait_beats(8);
    tick();
    tick();
    check("t3_active_done", 32'(replay_active), 32'd0);
    check_beat(6, 4'd4, 16'd4);
    check_beat(7, 4'd5, 16'd5);
    push(16'd6);
    EN = 1'b1;
    wait_beats(9);
    EN = 1'b0;
    tick();
    check_beat(8, 4'd6, 16'd6);
    check("t3_count_after", 32'(replay_count), 32'd3);

    // Fill the store: ten queued words but only eight fetched until an ACK.
    send_ack(1'b0, 4'd6);
    check("t4_count_clear", 32'(replay_count), 32'd0);
    base_rd = rd_cnt;
    for (int i = 0; i < 10; i++) push(DATA_W'(16'h100 + i));
    EN = 1'b1;
    repeat (60) tick();
    check("t4_rd_full", 32'(rd_cnt - base_rd), 32'd8);
    check("t4_full", 32'(REPLAY_FULL), 32'd1);
    check("t4_count", 32'(replay_count), 32'd8);
    send_ack(1'b0, 4'd7);
    repeat (12) tick();
    EN = 1'b0;
    check("t4_rd_after_ack", 32'(rd_cnt - base_rd), 32'd9);
    check("t4_full_again", 32'(REPLAY_FULL), 32'd1);
    wait_beats(18);
    check_beat(17, 4'd15, 16'h108);

    // Stale and out-of-range ACKs change nothing; then sequence wraps 15 -> 0.
    send_ack(1'b0, 4'd7);
    check("t5_stale", 32'(replay_count), 32'd8);
    send_ack(1'b0, 4'd0);
    check("t5_invalid", 32'(replay_count), 32'd8);
    send_ack(1'b0, 4'd15);
    check("t5_ack_all", 32'(replay_count), 32'd0);
    EN = 1'b1;
    wait_beats(19);
    EN = 1'b0;
    tick();
    check_beat(18, 4'd0, 16'h109);
    check("t5_count", 32'(replay_count), 32'd1);

    // Four NAKs without an intervening ACK: retrain on the fourth only.
    send_ack(1'b1, 4'd0);
    check("t6_nak1_retrain", 32'(link_retrain), 32'd0);
    check("t6_nak1_count", 32'(replay_count), 32'd0);
    send_ack(1'b1, 4'd0);
    check("t6_nak2_retrain", 32'(link_retrain), 32'd0);
    send_ack(1'b1, 4'd0);
    check("t6_nak3_retrain", 32'(link_retrain), 32'd0);
    send_ack(1'b1, 4'd0);
    check("t6_nak4_retrain", 32'(link_retrain), 32'd1);
    tick();
    check("t6_retrain_pulse", 32'(link_retrain), 32'd0);
    check("t6_no_replay", 32'(replay_active), 32'd0);

    // Reset while a word is held in S_SEND.
    push(16'h0BEE);
    tx_ready = 1'b0;
    EN       = 1'b1;
    k = 0;
    while (!tx_valid && k < 20) begin
      tick();
      k++;
    end
    check("t7_valid", 32'(tx_valid), 32'd1);
    check("t7_seq", 32'(tx_seq), 32'd1);
    check("t7_data", 32'(tx_data), 32'h0BEE);
    repeat (3) tick();
    check("t7_hold_valid", 32'(tx_valid), 32'd1);
    check("t7_hold_seq", 32'(tx_seq), 32'd1);
    check("t7_count", 32'(replay_count), 32'd1);
    EN  = 1'b0;
    Rst = 1'b1;
    tick();
    check("t7_rst_valid", 32'(tx_valid), 32'd0);
    check("t7_rst_count", 32'(replay_count), 32'd0);
    Rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
